// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: bundles the fetch stage's memory, decode and redirect signals.
// Signals:
//   imem_req/imem_addr (fetch -> memory), imem_gnt/imem_rvalid/imem_rdata (memory -> fetch)
//   inst_valid/Instruction/inst_pc (fetch -> decode), inst_ready (decode -> fetch)
//   branch_taken/branch_base_pc/extended (execute -> fetch)
// Modports: master = fetch stage, slave = its environment.
interface instruction_fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] Instruction;
    logic [63:0] inst_pc;
    logic        branch_taken;
    logic [63:0] branch_base_pc;
    logic [63:0] extended;

    modport master (
        output imem_req, imem_addr, inst_valid, Instruction, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, branch_taken, branch_base_pc, extended
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, Instruction, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready, branch_taken, branch_base_pc, extended
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: LEGv8 fetch stage owning the PC, issuing word fetches and buffering them for decode.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    instruction_fetch_if.master: imem request/grant/response, decode valid/ready with
//          Instruction/inst_pc, and branch redirect (branch_taken, branch_base_pc, extended)
//   fetch_count/flush_count  present only when IFETCH_PERF_EN is defined
// Parameters: RESET_PC (PC after reset), FIFO_DEPTH (buffer entries, power of two, >= 2).
module instruction_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
`ifdef IFETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count,
    instruction_fetch_if.master bus
`else
    instruction_fetch_if.master bus
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t        state, state_n;
    logic [63:0]   pc, target;
    logic [31:0]   buf_inst [FIFO_DEPTH];
    logic [63:0]   buf_pc   [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_n;
    logic          bt, push, pop, credit;

    assign bt      = bus.branch_taken;
    // offset is in words; shifting the full 64-bit value drops the top two bits, giving mod 2^64
    assign target  = bus.branch_base_pc + (bus.extended << 2);
    assign push    = state == WAIT && bus.imem_rvalid && !bt;
    assign pop     = bus.inst_valid && bus.inst_ready && !bt;
    assign count_n = count + CW'(push) - CW'(pop);
    // credit is only consulted when nothing is outstanding afterwards (IDLE, or a response landing)
    assign credit  = count_n < CW'(FIFO_DEPTH);

    assign bus.imem_addr   = pc;
    assign bus.inst_valid  = count != '0;
    assign bus.Instruction = buf_inst[rd_ptr];
    assign bus.inst_pc     = buf_pc[rd_ptr];

    always_comb begin
        state_n = state;
        if (bt)
            // a response landing with the redirect is simply discarded; otherwise it must be drained
            state_n = (state == WAIT || state == DROP) ? (bus.imem_rvalid ? REQ : DROP) :
                      state == REQ ? (bus.imem_gnt ? DROP : REQ) : REQ;
        else
            state_n = state == IDLE ? (credit ? REQ : IDLE) :
                      state == REQ  ? (bus.imem_gnt ? WAIT : REQ) :
                      state == WAIT ? (bus.imem_rvalid ? (credit ? REQ : IDLE) : WAIT) :
                      (bus.imem_rvalid ? REQ : DROP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.imem_req <= 1'b0;
            pc           <= RESET_PC;
        end else begin
            state        <= state_n;
            bus.imem_req <= state_n == REQ;
            pc           <= bt ? target : (state == REQ && bus.imem_gnt) ? pc + 64'd4 : pc;
        end
    end

    // pc already advanced past the granted word while in WAIT, so the fetched PC is pc - 4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_inst[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (bt) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_inst[wr_ptr] <= bus.imem_rdata;
                buf_pc[wr_ptr]   <= pc - 64'd4;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push)
                fetch_count <= fetch_count + 32'd1;
            if (bt)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch with a behavioural instruction memory.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if bus();
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count, flush_count;
`endif

    instruction_fetch #(.RESET_PC(64'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef IFETCH_PERF_EN
        .fetch_count(fetch_count),
        .flush_count(flush_count),
`endif
        .bus(bus)
    );

    int          checks = 0;
    int          failures = 0;
    logic [95:0] exp_q [$];
    logic [63:0] gnt_log [$];
    int          resp_delay = 0;
    logic        stray = 1'b0;
    logic        pend = 1'b0;
    logic        live = 1'b0;
    int          cnt = 0;
    logic [63:0] raddr = '0;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hA5C3_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy, input int d);
        rst_n = 1'b0;
        bus.inst_ready = rdy;
        bus.imem_gnt = 1'b1;
        bus.branch_taken = 1'b0;
        resp_delay = d;
        tick;
        tick;
        gnt_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (gnt_log.size() < n && k < 100) begin
            tick;
            k++;
        end
        check("grant_wait", 64'(gnt_log.size() >= n), 64'd1);
    endtask

    task automatic wait_req;
        int k = 0;
        while (!bus.imem_req && k < 100) begin
            tick;
            k++;
        end
        check("req_wait", bus.imem_req, 1);
    endtask

    task automatic redirect(input logic [63:0] base, input logic [63:0] ext);
        bus.branch_taken = 1'b1;
        bus.branch_base_pc = base;
        bus.extended = ext;
        tick;
        bus.branch_taken = 1'b0;
    endtask

    // memory responder + scoreboard; everything here describes the upcoming rising edge
    always @(negedge clk) begin
        logic rvd, bt, hs;
        if (!rst_n) begin
            exp_q.delete();
            pend = 1'b0;
            live = 1'b0;
            bus.imem_rvalid = stray;
            bus.imem_rdata = 32'hDEAD_0BAD;
        end else begin
            rvd = pend && cnt == 0;
            bt = bus.branch_taken;
            hs = bus.imem_req && bus.imem_gnt;
            check("inst_valid", bus.inst_valid, 64'(exp_q.size() != 0));
            if (bus.inst_valid && exp_q.size() != 0) begin
                check("inst_pc", bus.inst_pc, exp_q[0][95:32]);
                check("Instruction", bus.Instruction, exp_q[0][31:0]);
                if (bus.inst_ready && !bt)
                    void'(exp_q.pop_front());
            end
            if (rvd) begin
                pend = 1'b0;
                if (live && !bt)
                    exp_q.push_back({raddr, word(raddr)});
            end else if (pend) begin
                cnt--;
                if (bt)
                    live = 1'b0;
            end
            if (bt)
                exp_q.delete();
            if (hs) begin
                pend = 1'b1;
                cnt = resp_delay;
                live = !bt;
                raddr = bus.imem_addr;
                gnt_log.push_back(bus.imem_addr);
            end
            bus.imem_rvalid = rvd || stray;
            bus.imem_rdata = rvd ? word(raddr) : 32'hDEAD_0BAD;
        end
    end

    initial begin
        bus.imem_gnt = 1'b0;
        bus.inst_ready = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_base_pc = '0;
        bus.extended = '0;
        tick;
        tick;
        check("rst_req", bus.imem_req, 0);
        check("rst_addr", bus.imem_addr, 64'h0);
        check("rst_valid", bus.inst_valid, 0);
        check("rst_inst", bus.Instruction, 0);
        check("rst_pc", bus.inst_pc, 0);

        // streaming fetch
        do_reset(1'b1, 0);
        wait_log(4);
        check("addr0", gnt_log[0], 64'h0);
        check("addr1", gnt_log[1], 64'h4);
        check("addr2", gnt_log[2], 64'h8);
        check("addr3", gnt_log[3], 64'hC);
        repeat (6) tick;

        // backpressure fills the buffer
        do_reset(1'b0, 0);
        repeat (10) tick;
        check("buffered_grants", 64'(gnt_log.size()), 64'd2);
        check("full_req", bus.imem_req, 0);
        check("full_head_pc", bus.inst_pc, 64'h0);
        bus.inst_ready = 1'b1;
        wait_log(3);
        check("resume_addr", gnt_log[2], 64'h8);
        repeat (4) tick;

        // redirect while waiting for a slow response
        resp_delay = 2;
        gnt_log.delete();
        wait_log(1);
        redirect(64'h40, 64'hFFFF_FFFF_FFFF_FFFE);
        check("drop_valid", bus.inst_valid, 0);
        check("drop_req", bus.imem_req, 0);
        resp_delay = 0;
        gnt_log.delete();
        wait_log(1);
        check("drop_target", gnt_log[0], 64'h38);
        repeat (6) tick;

        // redirect in REQ without grant
        bus.imem_gnt = 1'b0;
        wait_req;
        redirect(64'h100, 64'd3);
        check("req_redir_addr", bus.imem_addr, 64'h10C);
        check("req_redir_req", bus.imem_req, 1);
        gnt_log.delete();
        bus.imem_gnt = 1'b1;
        wait_log(1);
        check("req_redir_grant", gnt_log[0], 64'h10C);
        begin
            int k = 0;
            while (!bus.inst_valid && k < 50) begin
                tick;
                k++;
            end
        end
        check("req_redir_valid", bus.inst_valid, 1);
        check("req_redir_pc", bus.inst_pc, 64'h10C);
        repeat (4) tick;

        // redirect with simultaneous pop and response
        do_reset(1'b0, 0);
        wait_log(2);
        check("pre_flush_valid", bus.inst_valid, 1);
        bus.inst_ready = 1'b1;
        redirect(64'h200, 64'h0);
        check("flush_valid", bus.inst_valid, 0);
        check("flush_req", bus.imem_req, 1);
        gnt_log.delete();
        wait_log(1);
        check("flush_target", gnt_log[0], 64'h200);
        repeat (4) tick;

        // reset while waiting, then a stray response
        do_reset(1'b0, 3);
        wait_log(2);
        check("wait_valid", bus.inst_valid, 1);
        check("wait_req", bus.imem_req, 0);
        rst_n = 1'b0;
        #1;
        check("abort_req", bus.imem_req, 0);
        check("abort_addr", bus.imem_addr, 64'h0);
        check("abort_valid", bus.inst_valid, 0);
        check("abort_inst", bus.Instruction, 0);
        check("abort_pc", bus.inst_pc, 0);
        bus.imem_gnt = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        stray = 1'b1;
        repeat (4) begin
            tick;
            check("stray_valid", bus.inst_valid, 0);
        end
        stray = 1'b0;
        check("stray_addr", bus.imem_addr, 64'h0);

        // PC wrap
        resp_delay = 0;
        bus.inst_ready = 1'b1;
        wait_req;
        redirect(64'hFFFF_FFFF_FFFF_FFF8, 64'h0);
        gnt_log.delete();
        bus.imem_gnt = 1'b1;
        wait_log(3);
        check("wrap0", gnt_log[0], 64'hFFFF_FFFF_FFFF_FFF8);
        check("wrap1", gnt_log[1], 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap2", gnt_log[2], 64'h0);
        repeat (6) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage that sits directly upstream of the decode/sign-extend stage in the LEGv8 datapath. It owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake. Fetched words are buffered in a small FIFO and presented to decode with a valid/ready handshake. It also computes taken-branch targets as base PC + (sign-extended offset << 2), using the 64-bit offset produced by the sign-extend stage, and flushes any wrong-path work.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  64  byte address of requested word
imem_gnt  in  1  memory accepts request this cycle (handshake = imem_req & imem_gnt)
imem_rvalid  in  1  response word valid
imem_rdata  in  32  response instruction word
inst_valid  out  1  FIFO head valid to decode
inst_ready  in  1  decode accepts head this cycle
Instruction  out  32  FIFO head instruction word
inst_pc  out  64  PC of FIFO head
branch_taken  in  1  redirect strobe from execute
branch_base_pc  in  64  PC of the branch instruction
extended  in  64  sign-extended branch offset, in words

Behaviour:
- Reset (async assert, sync release): PC=RESET_PC, FIFO empty, state=IDLE. imem_req=0, imem_addr=RESET_PC, inst_valid=0, Instruction=0, inst_pc=0.
- Target = branch_base_pc + {extended[61:0],2'b00}, mod 2^64; low 2 bits always 00.
- Credit: a request may issue only when fifo_count + outstanding < FIFO_DEPTH. At most one request is outstanding.
- States:
  IDLE: imem_req=0. Go to REQ when credit is available.
  REQ: imem_req=1, imem_addr=PC. On gnt: PC<=PC+4, go to WAIT.
  WAIT: on imem_rvalid: push {imem_rdata, fetched PC} into FIFO, then go to REQ if credit remains, else IDLE.
  DROP: waits for the response of a squashed request. On imem_rvalid: discard the data, go to REQ.
- imem_addr and imem_req stay stable in REQ until gnt, except on redirect.
- Redirect (branch_taken=1) has priority over all other events in that cycle:
  - FIFO is cleared and inst_valid=0 next cycle; any same-cycle pop is ignored.
  - PC<=Target.
  - Next state:
    - from WAIT with no rvalid: DROP.
    - from WAIT with rvalid: response discarded, go to REQ.
    - from REQ with gnt the same cycle: request counts as squashed, go to DROP.
    - from REQ without gnt: stay in REQ; imem_addr=Target next cycle.
    - from IDLE: go to REQ.
    - from DROP: stay in DROP; PC is updated.
- FIFO behaviour:
  - Simultaneous push and pop when full is legal: the pop frees a slot the same cycle.
  - Pop occurs when inst_valid & inst_ready.
  - Output is a registered head; latency from rvalid to inst_valid is 1 cycle.
- PC wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
- Reset asserted mid-transaction aborts immediately. Any later rvalid arriving in IDLE is ignored.

Optional Feature:
IFETCH_PERF_EN: adds output ports fetch_count[31:0] and flush_count[31:0], both reset to 0 and wrapping.
- fetch_count increments on every FIFO push.
- flush_count increments on every cycle with branch_taken=1.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=0, gnt=1 always, rvalid one cycle after gnt, inst_ready=1 -> imem_addr sequence 0,4,8,C; Instruction/inst_pc pairs emerge in order, 1 cycle after each rvalid.
- inst_ready=0 for 10 cycles -> exactly 2 words buffered (PCs 0,4), imem_req=0, no third grant. Release ready -> 0 then 4 pop, fetching resumes at 8.
- branch_taken in WAIT, base=0x40, extended=64'hFFFF_FFFF_FFFF_FFFE -> next rvalid data discarded (DROP), next imem_addr=0x38, FIFO empty.
- branch_taken in REQ with gnt low, base=0x100, extended=3 -> imem_addr becomes 0x10C the next cycle; no DROP; first delivered inst_pc=0x10C.
- Redirect with simultaneous pop and rvalid -> FIFO empty, response dropped, next fetch at the target.
- Reset asserted during WAIT -> outputs return to reset values immediately, imem_addr=RESET_PC; a stray rvalid afterwards produces no inst_valid.
